// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 RGB convolution datapath: raster position,
// line-buffer shift enables, window-valid flag and coefficient storage.
module conv_window_ctrl #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int CW     = 11,
   parameter int COEF_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              lb_shift_en,
   output logic              win_valid,
   output logic [CW-1:0]     col,
   output logic [CW-1:0]     row,
   output logic              busy,
   output logic              frame_done,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [COEF_W-1:0] cfg_data,
   output logic              cfg_err,
   output logic [9*COEF_W-1:0] coef
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      CONV,
      DONE
   } state_t;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

   state_t state;
   state_t state_nx;
   logic   accept;
   logic   last_col;
   logic   cfg_ok;

   assign pix_ready = (state == FILL) || (state == CONV);
   assign busy      = (state != IDLE);
   assign accept    = pix_valid & pix_ready;
   assign last_col  = (col == COL_LAST);
   assign cfg_ok    = cfg_we && (state == IDLE) && (cfg_addr <= 4'd8);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = FILL;
         FILL: if (accept && last_col && row == CW'(1)) state_nx = CONV;
         CONV: if (accept && last_col && row == ROW_LAST) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         lb_shift_en <= 1'b0;
         win_valid   <= 1'b0;
         frame_done  <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state       <= state_nx;
         lb_shift_en <= accept;
         // window is complete once two full lines and two pixels precede it
         win_valid   <= accept && (row >= CW'(2)) && (col >= CW'(2));
         frame_done  <= (state_nx == DONE);
         cfg_err     <= cfg_we && !cfg_ok;
         if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
         end else if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + CW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         coef <= '0;
         coef[4*COEF_W +: COEF_W] <= COEF_W'(1);
      end else if (cfg_ok) begin
         coef[int'(cfg_addr)*COEF_W +: COEF_W] <= cfg_data;
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: vector table, corner sequences and random
// stimulus against a position-count reference model.
module tb_conv_window_ctrl;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int CW  = 11;
   localparam int CFW = 8;
   localparam logic [71:0] ID = 72'h000000000100000000;
   localparam logic [71:0] C1 = 72'h000000000100000005;
   localparam logic [71:0] C2 = 72'hFF0000000100000005;

   logic clk = 1'b0;
   logic resetn, start, pix_valid, cfg_we;
   logic [3:0] cfg_addr;
   logic [CFW-1:0] cfg_data;
   logic pix_ready, lb_shift_en, win_valid, busy, frame_done, cfg_err;
   logic [CW-1:0] col, row;
   logic [9*CFW-1:0] coef;

   conv_window_ctrl #(
      .IMG_W(W), .IMG_H(H), .CW(CW), .COEF_W(CFW)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .lb_shift_en(lb_shift_en), .win_valid(win_valid),
      .col(col), .row(row), .busy(busy), .frame_done(frame_done),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .coef(coef)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: frame position as a plain pixel count
   bit m_act, m_done;
   int m_n;
   logic [7:0] m_coef [9];
   bit e_lb, e_win, e_fd, e_err;

   typedef struct {
      logic rst, st, pv, we;
      logic [3:0] a;
      logic [7:0] d;
      logic e_ready, e_busy, e_err, e_lb;
      logic [71:0] e_coef;
   } vec_t;

   task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] mcoef();
      logic [71:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v[k*8 +: 8] = m_coef[k];
      return v;
   endfunction

   task automatic model_edge();
      bit idle, acc;
      if (resetn) begin
         m_act = 0; m_done = 0; m_n = 0;
         for (int k = 0; k < 9; k++) m_coef[k] = (k == 4) ? 8'd1 : 8'd0;
         e_lb = 0; e_win = 0; e_fd = 0; e_err = 0;
         return;
      end
      idle  = !m_act && !m_done;
      acc   = pix_valid && m_act;
      e_lb  = acc;
      e_win = acc && (m_n / W >= 2) && (m_n % W >= 2);
      e_err = cfg_we && (!idle || cfg_addr > 4'd8);
      if (cfg_we && idle && cfg_addr <= 4'd8) m_coef[cfg_addr] = cfg_data;
      e_fd = 0;
      if (m_done) m_done = 0;
      else if (idle && start) begin
         m_act = 1; m_n = 0;
      end else if (acc) begin
         m_n++;
         if (m_n == W * H) begin
            m_n = 0; m_act = 0; m_done = 1; e_fd = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("ready", 72'(pix_ready), 72'(m_act));
      chk("busy", 72'(busy), 72'(m_act | m_done));
      chk("col", 72'(col), 72'(m_n % W));
      chk("row", 72'(row), 72'(m_n / W));
      chk("lb_shift", 72'(lb_shift_en), 72'(e_lb));
      chk("win", 72'(win_valid), 72'(e_win));
      chk("frame_done", 72'(frame_done), 72'(e_fd));
      chk("cfg_err", 72'(cfg_err), 72'(e_err));
      chk("coef", coef, mcoef());
   endtask

   task automatic step(bit rs, bit st, bit pv, bit we,
                       logic [3:0] a, logic [7:0] d);
      resetn = rs; start = st; pix_valid = pv;
      cfg_we = we; cfg_addr = a; cfg_data = d;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   vec_t tv [7];
   int n_lb, n_win, n_fd, first, fd_at;

   initial begin
      tv[0] = '{1, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 0, ID};
      tv[1] = '{0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 0, ID};
      tv[2] = '{0, 0, 1, 0, 4'd0, 8'h00, 0, 0, 0, 0, ID};
      tv[3] = '{0, 0, 1, 1, 4'd0, 8'h05, 0, 0, 0, 0, C1};
      tv[4] = '{0, 0, 0, 1, 4'd8, 8'hFF, 0, 0, 0, 0, C2};
      tv[5] = '{0, 0, 0, 1, 4'd9, 8'h33, 0, 0, 1, 0, C2};
      tv[6] = '{0, 0, 1, 0, 4'd0, 8'h00, 0, 0, 0, 0, C2};

      for (int i = 0; i < 7; i++) begin
         step(tv[i].rst, tv[i].st, tv[i].pv, tv[i].we, tv[i].a, tv[i].d);
         chk("tbl_ready", 72'(pix_ready), 72'(tv[i].e_ready));
         chk("tbl_busy", 72'(busy), 72'(tv[i].e_busy));
         chk("tbl_err", 72'(cfg_err), 72'(tv[i].e_err));
         chk("tbl_lb", 72'(lb_shift_en), 72'(tv[i].e_lb));
         chk("tbl_coef", coef, tv[i].e_coef);
         chk("tbl_pos", 72'({row, col}), 72'(0));
      end

      // continuous frame
      step(0, 1, 0, 0, 0, 0);
      n_lb = 0; n_win = 0; n_fd = 0; first = -1; fd_at = -1;
      for (int i = 0; i < 48; i++) begin
         step(0, 0, 1, 0, 0, 0);
         if (lb_shift_en) n_lb++;
         if (win_valid) begin
            if (first < 0) first = i;
            n_win++;
         end
         if (frame_done) begin n_fd++; fd_at = i; end
      end
      chk("a_lb_cnt", 72'(n_lb), 72'(48));
      chk("a_win_cnt", 72'(n_win), 72'(24));
      chk("a_first_win", 72'(first), 72'(18));
      chk("a_fd_cnt", 72'(n_fd), 72'(1));
      chk("a_fd_at", 72'(fd_at), 72'(47));
      step(0, 0, 0, 0, 0, 0);
      chk("a_busy_end", 72'(busy), 72'(0));

      // alternating valid
      step(0, 1, 0, 0, 0, 0);
      n_lb = 0; n_win = 0; n_fd = 0; fd_at = -1;
      for (int i = 0; i < 96; i++) begin
         step(0, 0, (i % 2) == 0, 0, 0, 0);
         if (lb_shift_en) n_lb++;
         if (win_valid) n_win++;
         if (frame_done) begin n_fd++; fd_at = i; end
      end
      chk("b_lb_cnt", 72'(n_lb), 72'(48));
      chk("b_win_cnt", 72'(n_win), 72'(24));
      chk("b_fd_cnt", 72'(n_fd), 72'(1));
      chk("b_fd_at", 72'(fd_at), 72'(94));
      chk("b_busy_end", 72'(busy), 72'(0));

      // write while busy is rejected
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 4'd3, 8'hAA);
      chk("c_err_busy", 72'(cfg_err), 72'(1));
      chk("c_coef_busy", coef, C2);
      for (int i = 0; i < 200; i++) begin
         step(0, 0, 1, 0, 0, 0);
         if (!busy) break;
      end
      chk("c_drain", 72'(busy), 72'(0));

      // write and start in the same cycle
      step(0, 1, 0, 1, 4'd4, 8'h77);
      chk("w_coef4", 72'(coef[39:32]), 72'(8'h77));
      chk("w_busy", 72'(busy), 72'(1));
      for (int i = 0; i < 200; i++) begin
         step(0, 0, 1, 0, 0, 0);
         if (!busy) break;
      end
      chk("w_drain", 72'(busy), 72'(0));

      // restart ignored mid-frame, then reset aborts the frame
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 29; i++) step(0, i == 19, 1, 0, 0, 0);
      chk("d_pos29", 72'({row, col}), 72'({11'd3, 11'd5}));
      step(1, 0, 1, 0, 0, 0);
      chk("d_col", 72'(col), 72'(0));
      chk("d_row", 72'(row), 72'(0));
      chk("d_coef", coef, ID);
      chk("d_busy", 72'(busy), 72'(0));
      n_fd = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, 0);
         if (frame_done) n_fd++;
      end
      chk("d_no_fd", 72'(n_fd), 72'(0));
      step(0, 1, 0, 0, 0, 0);
      n_lb = 0; n_fd = 0;
      for (int i = 0; i < 49; i++) begin
         step(0, 0, 1, 0, 0, 0);
         if (lb_shift_en) n_lb++;
         if (frame_done) n_fd++;
      end
      chk("d_lb_cnt", 72'(n_lb), 72'(48));
      chk("d_fd_cnt", 72'(n_fd), 72'(1));

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 399) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0,
              4'($urandom_range(0, 15)),
              8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
